// File: rtl/sid_bus_writer_if.sv
// Write-request handshake into the SID bus writer.
// The sequencer drives addr/data/valid; the writer returns ready.
interface sid_bus_writer_if;
    logic       WR_VALID;
    logic       WR_READY;
    logic [4:0] WR_ADDR;
    logic [7:0] WR_DATA;

    modport master (
        output WR_VALID,
        output WR_ADDR,
        output WR_DATA,
        input  WR_READY
    );

    modport slave (
        input  WR_VALID,
        input  WR_ADDR,
        input  WR_DATA,
        output WR_READY
    );
endinterface

// File: rtl/sid_bus_writer.sv
// SID pin driver: phi2 generation, power-on reset hold, and a
// FIFO of register writes replayed as chip-select strobes.
module sid_bus_writer #(
    parameter int DIV          = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int RESET_CYCLES = 16
) (
    input  logic                          C6_CLK_8MHZ,
    input  logic                          RESET,
    sid_bus_writer_if.slave               wr,
    output logic                          SID_CLK,
    output logic                          SID_NOTRES,
    output logic                          SID_NOTCS,
    output logic [4:0]                    SID_ADDR,
    output logic [7:0]                    SID_DATA,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          BUSY
);
    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(RESET_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);
    localparam logic [PW-1:0] PH_ARM  = PW'(DIV / 2 - 2);
    localparam logic [PW-1:0] PH_REL  = PW'(DIV - 3);
    localparam logic [IW-1:0] RC_LAST = IW'(RESET_CYCLES - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, STROBE, HOLD} state_t;

    state_t          state;
    state_t          state_n;
    logic [PW-1:0]   ph;
    logic [PW-1:0]   ph_n;
    logic [IW-1:0]   init_cnt;
    logic [12:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            cs_nx;

    assign ph_n        = (ph == PH_LAST) ? '0 : ph + 1'b1;
    assign wr.WR_READY = SID_NOTRES && (FIFO_LEVEL < LVL_FULL);
    assign push        = wr.WR_VALID && wr.WR_READY;
    assign BUSY        = (FIFO_LEVEL != '0) || (state != IDLE);

    // Strobe edges are registered one clock early so they land
    // one clock before the phi2 rise and one clock after its fall.
    always_comb begin
        state_n = state;
        cs_nx   = SID_NOTCS;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ph == PH_LAST && FIFO_LEVEL != '0 && SID_NOTRES) begin
                    pop     = 1'b1;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                if (ph == PH_ARM) begin
                    cs_nx   = 1'b0;
                    state_n = STROBE;
                end
            end
            STROBE: begin
                if (ph == '0) begin
                    cs_nx   = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (ph == PH_REL) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge C6_CLK_8MHZ) begin
        if (push) mem[wr_ptr] <= {wr.WR_ADDR, wr.WR_DATA};
    end

    always_ff @(posedge C6_CLK_8MHZ) begin
        if (RESET) begin
            ph         <= '0;
            SID_CLK    <= 1'b0;
            SID_NOTRES <= 1'b0;
            init_cnt   <= '0;
            state      <= IDLE;
            SID_NOTCS  <= 1'b1;
            SID_ADDR   <= '0;
            SID_DATA   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_LEVEL <= '0;
        end else begin
            ph        <= ph_n;
            SID_CLK   <= (ph_n >= PH_HALF);
            state     <= state_n;
            SID_NOTCS <= cs_nx;
            if (ph == PH_LAST && !SID_NOTRES) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == RC_LAST) SID_NOTRES <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                {SID_ADDR, SID_DATA} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop)      FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
            else if (!push && pop) FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
        end
    end
endmodule

// File: tb/tb_sid_bus_writer.sv
// Bench for sid_bus_writer: a timeline model of the chip pins is
// compared against the DUT every clock under directed and random writes.
module tb_sid_bus_writer;
    localparam int DIV   = 8;
    localparam int DEPTH = 4;
    localparam int RC    = 16;
    localparam int INIT  = RC * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       sid_clk;
    logic       sid_notres;
    logic       sid_notcs;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic [2:0] fifo_level;
    logic       busy;

    always #5 clk = ~clk;

    sid_bus_writer_if wr();

    sid_bus_writer #(
        .DIV(DIV),
        .FIFO_DEPTH(DEPTH),
        .RESET_CYCLES(RC)
    ) dut (
        .C6_CLK_8MHZ(clk),
        .RESET(rst),
        .wr(wr),
        .SID_CLK(sid_clk),
        .SID_NOTRES(sid_notres),
        .SID_NOTCS(sid_notcs),
        .SID_ADDR(sid_addr),
        .SID_DATA(sid_data),
        .FIFO_LEVEL(fifo_level),
        .BUSY(busy)
    );

    // Model: t counts clocks since reset release; s0 is the cycle in
    // which the current/last write became visible on the bus.
    int          t;
    int          s0;
    logic [12:0] q[$];
    logic [12:0] last;
    bit          acc;
    int          checks;
    int          passes;

    function automatic logic [20:0] expv();
        bit nr  = t >= INIT;
        bit csl = (t >= s0 + DIV / 2 - 1) && (t <= s0 + DIV);
        bit fb  = (t >= s0) && (t <= s0 + 2 * DIV - 3);
        bit ck  = (t % DIV) >= DIV / 2;
        bit rdy = nr && (q.size() < DEPTH);
        bit bz  = (q.size() != 0) || fb;
        return {ck, nr, !csl, last, 3'(q.size()), rdy, bz};
    endfunction

    function automatic logic [20:0] actv();
        return {sid_clk, sid_notres, sid_notcs, sid_addr,
                sid_data, fifo_level, wr.WR_READY, busy};
    endfunction

    task automatic tick();
        bit rdy;
        @(posedge clk);
        if (rst) begin
            t = 0;
            q.delete();
            s0 = -1000;
            last = '0;
            acc = 1'b0;
        end else begin
            rdy = (t >= INIT) && (q.size() < DEPTH);
            acc = wr.WR_VALID && rdy;
            if ((t % DIV) == DIV - 1 && q.size() > 0 && t >= INIT
                && (t + 1 - s0) >= 2 * DIV) begin
                last = q.pop_front();
                s0 = t + 1;
            end
            if (acc) q.push_back({wr.WR_ADDR, wr.WR_DATA});
            t++;
        end
        #1;
    endtask

    task automatic test_reset();
        int rise = -1;
        rst = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (actv() !== expv())
                $display("FAIL reset t=%0d got %h exp %h", t, actv(), expv());
            else passes++;
        end
        rst = 1'b0;
        for (int i = 1; i <= INIT + 8; i++) begin
            tick();
            checks++;
            if (actv() !== expv())
                $display("FAIL init t=%0d got %h exp %h", t, actv(), expv());
            else passes++;
            if (rise < 0 && sid_notres === 1'b1) rise = i;
        end
        checks++;
        if (rise !== INIT)
            $display("FAIL notres_rise got %0d exp %0d", rise, INIT);
        else passes++;
    endtask

    task automatic test_single();
        int  low = 0;
        bit  ok = 1'b0;
        wr.WR_ADDR  = 5'h18;
        wr.WR_DATA  = 8'h0F;
        wr.WR_VALID = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            checks++;
            if (actv() !== expv())
                $display("FAIL single_push t=%0d got %h exp %h", t, actv(), expv());
            else passes++;
            ok = acc;
        end
        wr.WR_VALID = 1'b0;
        checks++;
        if (!ok) $display("FAIL single_accept got 0 exp 1");
        else passes++;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (actv() !== expv())
                $display("FAIL single t=%0d got %h exp %h", t, actv(), expv());
            else passes++;
            if (sid_notcs === 1'b0) low++;
        end
        checks++;
        if (low !== DIV / 2 + 2)
            $display("FAIL cs_width got %0d exp %0d", low, DIV / 2 + 2);
        else passes++;
        checks++;
        if ({sid_addr, sid_data} !== 13'h180F)
            $display("FAIL single_bus got %h exp %h", {sid_addr, sid_data}, 13'h180F);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int  n = 0;
        int  falls[$];
        bit  prev = 1'b1;
        bit  sawfull = 1'b0;
        wr.WR_ADDR  = 5'd0;
        wr.WR_DATA  = 8'hA0;
        wr.WR_VALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++;
            if (actv() !== expv())
                $display("FAIL b2b t=%0d got %h exp %h", t, actv(), expv());
            else passes++;
            if (prev && sid_notcs === 1'b0) falls.push_back(t);
            prev = sid_notcs;
            if (fifo_level === 3'd4 && wr.WR_READY === 1'b0) sawfull = 1'b1;
            if (acc && n < 5) begin
                n++;
                wr.WR_ADDR = 5'(n);
                wr.WR_DATA = 8'hA0 + 8'(n);
                if (n == 5) wr.WR_VALID = 1'b0;
            end
        end
        checks++;
        if (n !== 5) $display("FAIL b2b_accepted got %0d exp 5", n);
        else passes++;
        checks++;
        if (!sawfull) $display("FAIL b2b_full got 0 exp 1");
        else passes++;
        checks++;
        if (falls.size() !== 5)
            $display("FAIL b2b_strobes got %0d exp 5", falls.size());
        else passes++;
        for (int k = 1; k < falls.size(); k++) begin
            checks++;
            if (falls[k] - falls[k-1] !== 2 * DIV)
                $display("FAIL b2b_gap got %0d exp %0d", falls[k] - falls[k-1], 2 * DIV);
            else passes++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if (!wr.WR_VALID || acc) begin
                wr.WR_VALID = 1'($urandom_range(0, 1));
                wr.WR_ADDR  = 5'($urandom);
                wr.WR_DATA  = 8'($urandom);
            end
            tick();
            checks++;
            if (actv() !== expv())
                $display("FAIL random t=%0d got %h exp %h", t, actv(), expv());
            else passes++;
        end
        wr.WR_VALID = 1'b0;
    endtask

    task automatic test_reset_mid_strobe();
        bit hit = 1'b0;
        wr.WR_VALID = 1'b1;
        for (int i = 0; i < 300 && !hit; i++) begin
            wr.WR_ADDR = 5'($urandom);
            wr.WR_DATA = 8'($urandom);
            tick();
            checks++;
            if (actv() !== expv())
                $display("FAIL mid_fill t=%0d got %h exp %h", t, actv(), expv());
            else passes++;
            hit = (t >= s0 + DIV / 2 - 1) && (t <= s0 + DIV) && (q.size() >= 3);
        end
        wr.WR_VALID = 1'b0;
        checks++;
        if (!hit || sid_notcs !== 1'b0)
            $display("FAIL mid_reach got %b exp 0", sid_notcs);
        else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({sid_notcs, sid_notres, fifo_level, sid_addr} !== {1'b1, 1'b0, 3'd0, 5'd0})
            $display("FAIL mid_reset got %b%b %0d %h exp 10 0 00",
                     sid_notcs, sid_notres, fifo_level, sid_addr);
        else passes++;
    endtask

    task automatic test_init_push();
        int acc_t = -1;
        int fall_t = -1;
        bit prev = 1'b1;
        for (int i = 1; i <= INIT + 40; i++) begin
            if (i == 50) begin
                wr.WR_ADDR  = 5'h0B;
                wr.WR_DATA  = 8'h55;
                wr.WR_VALID = 1'b1;
            end
            tick();
            checks++;
            if (actv() !== expv())
                $display("FAIL init_push t=%0d got %h exp %h", t, actv(), expv());
            else passes++;
            if (acc && acc_t < 0) begin
                acc_t = t - 1;
                wr.WR_VALID = 1'b0;
            end
            if (prev && sid_notcs === 1'b0 && fall_t < 0) fall_t = t;
            prev = sid_notcs;
        end
        checks++;
        if (acc_t !== INIT)
            $display("FAIL init_accept got %0d exp %0d", acc_t, INIT);
        else passes++;
        checks++;
        if (fall_t !== INIT + DIV + DIV / 2 - 1)
            $display("FAIL init_strobe got %0d exp %0d", fall_t, INIT + DIV + DIV / 2 - 1);
        else passes++;
        checks++;
        if ({sid_addr, sid_data} !== 13'h0B55)
            $display("FAIL init_bus got %h exp %h", {sid_addr, sid_data}, 13'h0B55);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        t = 0;
        s0 = -1000;
        last = '0;
        acc = 1'b0;
        rst = 1'b1;
        wr.WR_VALID = 1'b0;
        wr.WR_ADDR  = '0;
        wr.WR_DATA  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_reset_mid_strobe();
        test_init_push();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
